puerto_tx_serie: RTL and testbench

Serial transmitter attached to one CPU output port. It is the outbound counterpart of the input-port and interrupt path. The CPU writes a byte with the port's write-enable, and the block serializes it as 8N1 with a one-byte holding buffer. It returns status through an input port and raises a one-cycle completion request on an interrupt-manager input line.

---
 rtl/puerto_tx_serie_pkg.sv | 9 +
 rtl/puerto_tx_serie_divisor_baudios.sv | 18 +
 rtl/registro_en.sv | 14 +
 rtl/puerto_tx_serie.sv | 77 +++++++
 tb/tb_puerto_tx_serie.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/puerto_tx_serie_pkg.sv
// puerto_tx_serie_pkg: shared state encodings, frame constants and status bit positions
package puerto_tx_serie_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = 10;
  localparam int BUSY = 7;
  localparam int HOLD = 6;
  localparam int OVR = 5;
endpackage

// File: rtl/puerto_tx_serie_divisor_baudios.sv
// divisor_baudios: bit-period counter emitting a one-cycle bit_end tick every CLKS_PER_BIT cycles
module divisor_baudios #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic bit_end
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign bit_end = en && cnt == LAST;
  always_ff @(posedge clk)
    if (reset || restart) cnt <= '0;
    else if (en) cnt <= bit_end ? '0 : cnt + W'(1);
endmodule

// File: rtl/registro_en.sv
// registro_en: enabled register with synchronous reset
module registro_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/puerto_tx_serie.sv
// puerto_tx_serie: 8N1 serial transmitter with a one-byte holding buffer, status port and completion pulse
module puerto_tx_serie
  import puerto_tx_serie_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] din,
  input  logic       clr,
  output logic       tx,
  output logic       busy,
  output logic [7:0] status,
  output logic       int_tx
);
  state_t state, state_n;
  logic [DATA_BITS-1:0] hold, shifter, shifter_n;
  logic [2:0] idx, idx_n;
  logic hold_full, overrun, bit_end, drain, accept, tx_n;
  divisor_baudios #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_div (
    .clk, .reset, .en(state != IDLE), .restart(state == IDLE), .bit_end
  );
  registro_en #(.W(DATA_BITS)) u_hold (.clk, .reset, .en(accept), .d(din), .q(hold));
  assign int_tx = state == STOP && bit_end;
  // hold empties when the FSM picks it up, either from IDLE or at the end of a stop bit
  assign drain = hold_full && (state == IDLE || int_tx);
  assign accept = we && (!hold_full || drain);
  assign busy = state != IDLE || hold_full;
  always_comb begin
    status = '0;
    status[BUSY] = busy;
    status[HOLD] = hold_full;
    status[OVR] = overrun;
  end
  always_comb begin
    state_n = state;
    shifter_n = shifter;
    idx_n = idx;
    if (drain) begin
      state_n = START;
      shifter_n = hold;
    end else if (bit_end) begin
      case (state)
        START: begin
          state_n = DATA;
          idx_n = '0;
        end
        DATA: begin
          shifter_n = shifter >> 1;
          idx_n = idx + 3'd1;
          state_n = idx == 3'(DATA_BITS - 1) ? STOP : DATA;
        end
        STOP: state_n = IDLE;
        default: state_n = state;
      endcase
    end
    // line level follows the state being entered so tx is a clean register output
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shifter_n[0] : 1'b1;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      shifter <= '0;
      idx <= '0;
      hold_full <= 1'b0;
      overrun <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      shifter <= shifter_n;
      idx <= idx_n;
      hold_full <= accept || (hold_full && !drain);
      overrun <= (we && !accept) || (overrun && !clr);
      tx <= tx_n;
    end
endmodule

// File: tb/tb_puerto_tx_serie.sv
// tb_puerto_tx_serie: directed bench with a frame-decoding monitor checked against a byte scoreboard
module tb_puerto_tx_serie;
  localparam int CPB = 4;
  localparam int FLEN = 10 * CPB;
  logic clk = 1'b0, reset = 1'b1, we = 1'b0, clr = 1'b0;
  logic [7:0] din = '0;
  logic tx, busy, int_tx;
  logic [7:0] status;
  int vectors = 0, miscompares = 0, cyc = 0, t1 = 0, t2 = 0;
  logic [7:0] sb[$];

  puerto_tx_serie #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .we(we), .din(din), .clr(clr),
    .tx(tx), .busy(busy), .status(status), .int_tx(int_tx)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #400000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input bit expect_tx);
    din = b;
    we = 1'b1;
    if (expect_tx) sb.push_back(b);
    tick();
    we = 1'b0;
  endtask

  task automatic wait_int();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int_tx !== 1'b1 && n < 3 * FLEN);
    chk("int_seen", 32'(int_tx), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 4 * FLEN);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_status", 32'(status), 32'h00);
    tick();
  endtask

  // monitor: decodes each frame cycle by cycle against the next expected byte
  initial begin
    int pos = -1;
    logic tx_last = 1'b1;
    logic [9:0] fr = '1;
    forever begin
      @(negedge clk);
      if (reset) pos = -1;
      else begin
        if (pos < 0 && tx_last === 1'b1 && tx === 1'b0) begin
          pos = 0;
          if (sb.size() == 0) begin
            chk("unexpected_frame", 32'(sb.size()), 32'd1);
            fr = '1;
          end else fr = {1'b1, sb[0], 1'b0};
        end
        if (pos >= 0) begin
          chk("tx_bit", 32'(tx), 32'(fr[pos / CPB]));
          if (int_tx || pos == FLEN - 1) chk("int_pos", 32'(int_tx), 32'(pos == FLEN - 1));
          pos++;
          if (pos == FLEN) begin
            if (sb.size() > 0) void'(sb.pop_front());
            pos = -1;
          end
        end else if (int_tx) chk("stray_int", 32'(int_tx), 32'd0);
      end
      tx_last = tx;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_status", 32'(status), 32'h00);
    chk("rst_int", 32'(int_tx), 32'd0);
    tick();
    // single byte, latency and frame timing
    put(8'hA5, 1'b1);
    @(negedge clk);
    chk("lat_hold", 32'(status), 32'hC0);
    chk("lat_tx_high", 32'(tx), 32'd1);
    tick();
    @(negedge clk);
    chk("lat_tx_low", 32'(tx), 32'd0);
    chk("lat_status", 32'(status), 32'h80);
    t1 = cyc;
    wait_int();
    chk("a5_int_cycle", 32'(cyc - t1), 32'(FLEN - 1));
    wait_idle();
    // second write during DATA: contiguous frames
    put(8'h01, 1'b1);
    repeat (10) tick();
    put(8'hFF, 1'b1);
    wait_int();
    t1 = cyc;
    @(negedge clk);
    chk("b2b_start", 32'(tx), 32'd0);
    wait_int();
    t2 = cyc;
    chk("b2b_period", 32'(t2 - t1), 32'(FLEN));
    chk("b2b_ovr", 32'(status[5]), 32'd0);
    wait_idle();
    // three back-to-back writes: third one overruns
    din = 8'h11; we = 1'b1; sb.push_back(8'h11); tick();
    din = 8'h22; sb.push_back(8'h22); tick();
    din = 8'h33; tick();
    we = 1'b0;
    @(negedge clk);
    chk("ovr_set", 32'(status), 32'hE0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("ovr_clr", 32'(status), 32'hC0);
    wait_int();
    wait_int();
    wait_idle();
    // clr and overrun in the same cycle: set wins
    din = 8'h44; we = 1'b1; sb.push_back(8'h44); tick();
    din = 8'h55; sb.push_back(8'h55); tick();
    din = 8'h66; clr = 1'b1; tick();
    we = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("ovr_set_wins", 32'(status), 32'hE0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_int();
    wait_int();
    wait_idle();
    // reset during DATA bit 3
    put(8'h77, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 10);
    chk("rst_frame_start", 32'(tx), 32'd0);
    repeat (4 * CPB + 1) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_status", 32'(status), 32'h00);
    chk("mid_rst_int", 32'(int_tx), 32'd0);
    tick();
    reset = 1'b0;
    repeat (FLEN + 10) tick();
    put(8'h5A, 1'b1);
    wait_int();
    wait_idle();
    // write in the final STOP cycle with hold full
    put(8'h81, 1'b1);
    put(8'h82, 1'b1);
    wait_int();
    din = 8'h83;
    we = 1'b1;
    sb.push_back(8'h83);
    @(posedge clk);
    #1 we = 1'b0;
    @(negedge clk);
    chk("stop_write", 32'(status), 32'hC0);
    wait_int();
    @(negedge clk);
    chk("third_b2b", 32'(tx), 32'd0);
    wait_int();
    wait_idle();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
